mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one output channel through a 2-to-1 mux (sel=0 selects A, sel=1 selects B).
- Each requester presents a valid/ready/last stream. The arbiter grants one stream at a time, holds the grant for a burst, then rotates priority.
- Sits between two producer blocks and a single downstream consumer. The select it drives is the mux select.

Parameters:
- DATA_W, 8, width of each data stream and of out_data.
- MAX_BURST, 4, maximum beats per grant before a forced release (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a_valid  input  1  requester A has a beat
- a_data  input  DATA_W  requester A beat
- a_last  input  1  final beat of A's burst
- a_ready  output  1  A beat accepted this cycle
- b_valid  input  1  requester B has a beat
- b_data  input  DATA_W  requester B beat
- b_last  input  1  final beat of B's burst
- b_ready  output  1  B beat accepted this cycle
- out_valid  output  1  shared channel holds a beat
- out_data  output  DATA_W  shared channel beat (mux output)
- out_ready  input  1  consumer accepts the beat
- sel  output  1  registered mux select, 1 only while B is granted
- busy  output  1  a grant is active

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, sel=0, busy=0, out_valid=0, a_ready=0, b_ready=0.
  - Burst counter=0.
  - Priority register prio=0, meaning A wins the first tie.
- States:
  - IDLE: no grant. out_valid=0, both readies=0, sel holds 0.
  - GNT_A: sel=0, busy=1. out_valid=a_valid, out_data=a_data, a_ready=out_ready, b_ready=0.
  - GNT_B: sel=1, busy=1. out_valid=b_valid, out_data=b_data, b_ready=out_ready, a_ready=0.
- Output timing: out_valid, out_data and the readies are combinational from registered state plus live inputs. sel and busy are registered.
- IDLE transitions, evaluated each cycle:
  - Only a_valid → GNT_A next cycle.
  - Only b_valid → GNT_B next cycle.
  - Both valid → grant the side named by prio (0 = A, 1 = B).
  - Neither → stay in IDLE.
- Grant latency: a request seen in IDLE produces the first beat on out_data on the following cycle. The earliest transfer is therefore 1 cycle after valid is first seen.
- Transfer: a transfer occurs when out_valid and out_ready are both high in a GNT state. Each transfer increments the burst counter.
- Release: on a transfer with last=1, or with burst counter == MAX_BURST-1, the arbiter releases the grant. On the next edge:
  - state → IDLE, counter → 0.
  - prio → the opposite side of the one just served.
- No back-to-back handoff: there is always exactly one IDLE bubble cycle between grants.
- Hold behaviour:
  - Without a transfer, the grant is held indefinitely, including when out_ready=0 and when the granted valid drops. Requesters must keep valid/data stable until ready.
  - The non-granted requester's ready stays 0 regardless of its valid.
- last vs MAX_BURST: if last=1 and the counter is at MAX_BURST-1 on the same beat, there is a single release and no double rotation.
- MAX_BURST=1: every grant releases after one beat, giving strict alternation under continuous contention.
- Reset mid-burst: rst_n=0 during a grant forces the reset values on that edge. The beat in flight is not accepted (readies=0 after the edge), and prio returns to 0.
- Counter width: 4 bits. It never wraps, because it is cleared on release.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with a_valid=b_valid=1 → sel=0, busy=0, out_valid=0, a_ready=b_ready=0 throughout.
2. Single requester: a_valid=1, a_data=8'h11,8'h22,8'h33 with last on the 3rd beat, out_ready=1 → beats appear on out_data on cycles 1,2,3 after request, then 1 IDLE cycle, busy=0, sel=0.
3. Contention, round-robin: both valid continuously, last=0, MAX_BURST=4 → sequence A×4, IDLE, B×4 (sel=1), IDLE, A×4. b_ready stays 0 during A's burst.
4. Backpressure: grant B, out_ready=0 for 5 cycles with b_data=8'hA5 → out_valid=1, out_data=8'hA5 held, b_ready=0, counter unchanged. out_ready=1 → single transfer, counter=1.
5. Coincident last and limit: the 4th beat of A carries last=1 → one release, prio=1, and B is granted next when both are valid.
6. Reset mid-burst: after 2 beats of B, assert rst_n=0 for 1 cycle → state IDLE, sel=0, prio=0. With both valid after reset, A is granted first.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bundle of the two requester streams, the shared output channel and the
// arbiter status. The arbiter connects through the slave modport; the
// surrounding producers/consumer connect through the master modport.
interface mux_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_last;
    logic              a_ready;

    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_last;
    logic              b_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    logic              sel;
    logic              busy;

    modport master (
        output a_valid, a_data, a_last,
        input  a_ready,
        output b_valid, b_data, b_last,
        input  b_ready,
        input  out_valid, out_data,
        output out_ready,
        input  sel, busy
    );

    modport slave (
        input  a_valid, a_data, a_last,
        output a_ready,
        input  b_valid, b_data, b_last,
        output b_ready,
        output out_valid, out_data,
        input  out_ready,
        output sel, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving a 2-to-1 stream mux.
// A grant lasts until a beat with last=1 or MAX_BURST beats have moved,
// then one IDLE cycle follows and the tie-break priority flips to the
// side that was not just served.
module mux_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input logic             clk,
    input logic             rst_n,
    mux_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    // Counter value of the beat that hits the burst limit.
    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              prio;
    logic              sel_q;
    logic              busy_q;

    logic              out_valid_c;
    logic [DATA_W-1:0] mux_data;
    logic              a_ready_c;
    logic              b_ready_c;
    logic              cur_last;
    logic              xfer;
    logic              rel;

    // Output mux and readies: combinational from the registered grant plus live inputs.
    always_comb begin
        out_valid_c = 1'b0;
        mux_data    = '0;
        a_ready_c   = 1'b0;
        b_ready_c   = 1'b0;
        cur_last    = 1'b0;
        case (state)
            GNT_A: begin
                out_valid_c = bus.a_valid;
                mux_data    = bus.a_data;
                a_ready_c   = bus.out_ready;
                cur_last    = bus.a_last;
            end
            GNT_B: begin
                out_valid_c = bus.b_valid;
                mux_data    = bus.b_data;
                b_ready_c   = bus.out_ready;
                cur_last    = bus.b_last;
            end
            default: begin
            end
        endcase
        xfer = out_valid_c & bus.out_ready;
        rel  = xfer & (cur_last | (cnt == LAST_CNT));
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = mux_data;
    assign bus.a_ready   = a_ready_c;
    assign bus.b_ready   = b_ready_c;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;

    // Grant FSM: picks a side from IDLE, counts beats, releases and rotates priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            prio   <= 1'b0;
            sel_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.a_valid && (!bus.b_valid || !prio)) begin
                        state  <= GNT_A;
                        sel_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end else if (bus.b_valid) begin
                        state  <= GNT_B;
                        sel_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                GNT_A, GNT_B: begin
                    if (rel) begin
                        state  <= IDLE;
                        cnt    <= 4'd0;
                        sel_q  <= 1'b0;
                        busy_q <= 1'b0;
                        prio   <= (state == GNT_A);
                    end else if (xfer) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= 4'd0;
                    sel_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: queue-driven producers, a transaction-level
// reference model that predicts each cycle's outputs into a scoreboard, and
// a separate monitor that compares the DUT against the scoreboard.
module tb_mux_rr_arbiter;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic       sel;
        logic       busy;
        logic       ov;
        logic [7:0] od;
        logic       ar;
        logic       br;
    } exp_t;

    logic clk;
    logic rst_n;

    mux_rr_arbiter_if #(.DATA_W(8)) bus ();

    mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Producer queues and stimulus knobs
    beat_t a_q[$];
    beat_t b_q[$];
    bit    a_hold;
    bit    b_hold;
    bit    rst_cmd;
    bit    force_valid;
    bit    model_on;
    int    valid_pct;
    int    ready_pct;

    // Reference model: who owns the channel (0 none, 1 A, 2 B), beats moved
    // in this grant, and which side wins the next tie.
    int    owner;
    int    beats;
    int    turn;

    exp_t  sb[$];
    int    compared;
    int    mismatched;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic applyStimulus();
        rst_n         = rst_cmd;
        bus.out_ready = ($urandom_range(99) < ready_pct);
        if (force_valid) begin
            bus.a_valid = 1'b1;
            bus.a_data  = 8'($urandom);
            bus.a_last  = 1'b0;
            bus.b_valid = 1'b1;
            bus.b_data  = 8'($urandom);
            bus.b_last  = 1'b0;
        end else begin
            if (!a_hold && a_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                a_hold      = 1'b1;
                bus.a_valid = 1'b1;
                bus.a_data  = a_q[0].data;
                bus.a_last  = a_q[0].last;
            end else if (!a_hold) begin
                bus.a_valid = 1'b0;
                bus.a_data  = 8'($urandom);
                bus.a_last  = 1'b0;
            end
            if (!b_hold && b_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                b_hold      = 1'b1;
                bus.b_valid = 1'b1;
                bus.b_data  = b_q[0].data;
                bus.b_last  = b_q[0].last;
            end else if (!b_hold) begin
                bus.b_valid = 1'b0;
                bus.b_data  = 8'($urandom);
                bus.b_last  = 1'b0;
            end
        end
    endtask

    // Predict this cycle's outputs, then advance the model across the coming edge.
    task automatic modelStep();
        exp_t e;
        bit   took_last;
        e = '0;
        if (owner == 1) begin
            e.busy = 1'b1;
            e.ov   = bus.a_valid;
            e.od   = bus.a_data;
            e.ar   = bus.out_ready;
        end else if (owner == 2) begin
            e.sel  = 1'b1;
            e.busy = 1'b1;
            e.ov   = bus.b_valid;
            e.od   = bus.b_data;
            e.br   = bus.out_ready;
        end
        sb.push_back(e);

        if (!rst_n) begin
            owner = 0;
            beats = 0;
            turn  = 1;
        end else if (owner == 0) begin
            if (bus.a_valid && bus.b_valid) owner = turn;
            else if (bus.a_valid)           owner = 1;
            else if (bus.b_valid)           owner = 2;
        end else if (e.ov && bus.out_ready) begin
            if (owner == 1) begin
                took_last = bus.a_last;
                void'(a_q.pop_front());
                a_hold = 1'b0;
            end else begin
                took_last = bus.b_last;
                void'(b_q.pop_front());
                b_hold = 1'b0;
            end
            beats++;
            if (took_last || beats == MAX_BURST) begin
                turn  = (owner == 1) ? 2 : 1;
                owner = 0;
                beats = 0;
            end
        end
    endtask

    // Driver: new inputs just after each rising edge, model evaluation mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            applyStimulus();
            @(negedge clk);
            if (model_on) modelStep();
        end
    end

    // Monitor: pops one prediction per cycle and compares the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("sel",       {7'd0, bus.sel},       {7'd0, e.sel});
                checkOutput("busy",      {7'd0, bus.busy},      {7'd0, e.busy});
                checkOutput("out_valid", {7'd0, bus.out_valid}, {7'd0, e.ov});
                if (e.ov) checkOutput("out_data", bus.out_data, e.od);
                checkOutput("a_ready",   {7'd0, bus.a_ready},   {7'd0, e.ar});
                checkOutput("b_ready",   {7'd0, bus.b_ready},   {7'd0, e.br});
            end
        end
    end

    task automatic pushBurst(input bit side_b, input int len, input bit end_last);
        beat_t bt;
        for (int i = 0; i < len; i++) begin
            bt.data = 8'($urandom);
            bt.last = end_last && (i == len - 1);
            if (side_b) b_q.push_back(bt);
            else        a_q.push_back(bt);
        end
    endtask

    task automatic waitIdle(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (!(a_q.size() == 0 && b_q.size() == 0 && !a_hold && !b_hold && owner == 0)) begin
            @(posedge clk);
            n++;
            if (n > max_cycles) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL drain_%s: got timeout after %0d cycles expected idle", tag, n);
                break;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        beat_t bt;
        int    n;
        compared    = 0;
        mismatched  = 0;
        owner       = 0;
        beats       = 0;
        turn        = 1;
        a_hold      = 1'b0;
        b_hold      = 1'b0;
        model_on    = 1'b0;
        valid_pct   = 100;
        ready_pct   = 100;
        rst_cmd     = 1'b0;
        force_valid = 1'b1;
        rst_n       = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h00;
        bus.a_last  = 1'b0;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h00;
        bus.b_last  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset with both requesters valid
        $display("[TB] reset with both valid");
        @(posedge clk);
        model_on = 1'b1;
        repeat (2) @(posedge clk);
        rst_cmd     = 1'b1;
        force_valid = 1'b0;

        // Single requester, three beats ending with last
        $display("[TB] single requester");
        foreach (bt.data[i]) begin end
        bt.data = 8'h11; bt.last = 1'b0; a_q.push_back(bt);
        bt.data = 8'h22; bt.last = 1'b0; a_q.push_back(bt);
        bt.data = 8'h33; bt.last = 1'b1; a_q.push_back(bt);
        waitIdle(50, "single");

        // Continuous contention, bursts limited by MAX_BURST
        $display("[TB] contention");
        pushBurst(1'b0, 12, 1'b0);
        pushBurst(1'b1, 12, 1'b0);
        waitIdle(100, "contention");

        // Backpressure on a B grant
        $display("[TB] backpressure");
        ready_pct = 0;
        bt.data = 8'hA5; bt.last = 1'b1; b_q.push_back(bt);
        repeat (7) @(posedge clk);
        ready_pct = 100;
        waitIdle(50, "backpressure");

        // Last coinciding with the burst limit on A's fourth beat
        $display("[TB] coincident last and limit");
        pushBurst(1'b0, 4, 1'b1);
        pushBurst(1'b1, 2, 1'b1);
        waitIdle(50, "coincident");

        // Reset in the middle of a B burst
        $display("[TB] reset mid-burst");
        pushBurst(1'b1, 6, 1'b0);
        n = 0;
        while (!(owner == 2 && beats == 2)) begin
            @(posedge clk);
            n++;
            if (n > 50) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL midburst_wait: got timeout expected two B beats");
                break;
            end
        end
        rst_cmd = 1'b0;
        @(posedge clk);
        rst_cmd = 1'b1;
        pushBurst(1'b0, 3, 1'b1);
        waitIdle(100, "midburst");

        // Randomised traffic with random valid gaps and backpressure
        $display("[TB] random traffic");
        for (int seg = 0; seg < 10; seg++) begin
            for (int k = 0; k < 4; k++) begin
                pushBurst(1'b0, $urandom_range(1, 6), 1'b1);
                pushBurst(1'b1, $urandom_range(1, 6), 1'b1);
            end
            valid_pct = $urandom_range(40, 100);
            ready_pct = $urandom_range(30, 100);
            repeat (60) @(posedge clk);
        end
        valid_pct = 100;
        ready_pct = 100;
        waitIdle(2000, "random");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
